ram_sel_gen: RTL and testbench

Write-side sequencer that produces the 4-bit RAM selector, address and data consumed by every processor's RAM select decoder. When started, it accepts a stream of words over a valid/ready handshake. It distributes them in fixed order: first the RAM1 bank of each processor (selector = processor index), then the RAM2 bank of each processor (selector = processor index + 4). The block sits between the input loader and the bank of per-processor RAM select decoders, and signals completion once every RAM is filled.

---
 rtl/ram_sel_gen.sv | 154 +++++++++++++++
 tb/tb_ram_sel_gen.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ram_sel_gen.sv
// rtl/ram_sel_gen.sv - write-side sequencer feeding per-processor RAM select decoders
//
// Accepts a valid/ready word stream after start and writes it, in order, to the
// RAM1 bank of every processor (sel = proc) and then to the RAM2 bank of every
// processor (sel = proc + 4). Pulses done with the last write.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   begin a load sequence (honoured only when idle)
//   clear      in   synchronous abort to idle
//   data_in    in   stream word
//   data_valid in   data_in is valid
//   data_ready out  word accepted this cycle when data_valid is high
//   sel        out  RAM selector (4'hF when idle and not writing)
//   wr_addr    out  write address inside the selected RAM
//   wr_data    out  write data
//   wr_en      out  one-cycle write strobe per accepted word
//   busy       out  sequence in progress
//   done       out  one-cycle completion pulse, coincident with the last wr_en

module ram_sel_gen #(
  parameter int NUM_PROC      = 4,
  parameter int WORDS_PER_RAM = 4,
  parameter int DATA_W        = 8,
  parameter int AW            = $clog2(WORDS_PER_RAM)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clear,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [3:0]        sel,
  output logic [AW-1:0]     wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD1 = 2'd1,
    LOAD2 = 2'd2
  } state_t;

  localparam logic [AW-1:0] ADDR_LAST = AW'(WORDS_PER_RAM - 1);
  localparam logic [1:0]    PROC_LAST = 2'(NUM_PROC - 1);
  localparam logic [3:0]    SEL_IDLE  = 4'hF;

  state_t              state_q, state_d;
  logic [1:0]          proc_cnt_q, proc_cnt_d;
  logic [AW-1:0]       addr_cnt_q, addr_cnt_d;
  logic [3:0]          sel_q, sel_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                wr_en_q, wr_en_d;
  logic                done_q, done_d;
  logic                xfer;

  // Ready depends only on registered state, so there is no path from data_valid.
  assign data_ready = (state_q != IDLE);
  assign busy       = (state_q != IDLE);
  assign xfer       = data_valid & data_ready;

  assign sel     = sel_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_en   = wr_en_q;
  assign done    = done_q;

  always_comb begin
    state_d    = state_q;
    proc_cnt_d = proc_cnt_q;
    addr_cnt_d = addr_cnt_q;
    sel_d      = sel_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    done_d     = 1'b0;

    if (clear) begin
      // A transfer coincident with clear is dropped: no write is produced.
      state_d    = IDLE;
      proc_cnt_d = '0;
      addr_cnt_d = '0;
      sel_d      = SEL_IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          sel_d      = SEL_IDLE;
          proc_cnt_d = '0;
          addr_cnt_d = '0;
          if (start) begin
            state_d = LOAD1;
          end
        end
        LOAD1, LOAD2: begin
          if (xfer) begin
            wr_en_d   = 1'b1;
            wr_data_d = data_in;
            wr_addr_d = addr_cnt_q;
            // RAM2 selectors sit 4 above RAM1; NUM_PROC <= 4 keeps this in 4 bits.
            sel_d     = (state_q == LOAD2) ? {2'b01, proc_cnt_q} : {2'b00, proc_cnt_q};
            if (addr_cnt_q == ADDR_LAST) begin
              addr_cnt_d = '0;
              if (proc_cnt_q == PROC_LAST) begin
                proc_cnt_d = '0;
                if (state_q == LOAD1) begin
                  state_d = LOAD2;
                end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                end
              end else begin
                proc_cnt_d = proc_cnt_q + 2'd1;
              end
            end else begin
              addr_cnt_d = addr_cnt_q + AW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      proc_cnt_q <= '0;
      addr_cnt_q <= '0;
      sel_q      <= SEL_IDLE;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      proc_cnt_q <= proc_cnt_d;
      addr_cnt_q <= addr_cnt_d;
      sel_q      <= sel_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_ram_sel_gen.sv
// tb/tb_ram_sel_gen.sv - self-checking bench for ram_sel_gen

module tb_ram_sel_gen;

  localparam int NP = 4;
  localparam int W  = 4;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int N  = 2 * NP * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          clear;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic          data_ready;
  logic [3:0]    sel;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          busy;
  logic          done;

  ram_sel_gen #(
    .NUM_PROC(NP), .WORDS_PER_RAM(W), .DATA_W(DW), .AW(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .sel(sel), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model: sequence position k counts accepted words of the current run
  bit          m_active;
  int          m_k;
  logic [3:0]  e_sel;
  int          e_addr;
  int          e_data;
  bit          e_wr_en;
  bit          e_done;
  int          done_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_k = 0; e_sel = 4'hF; e_addr = 0; e_data = 0;
    e_wr_en = 0; e_done = 0;
  endtask

  task automatic check_outputs(input string ctx);
    check({ctx, ".wr_en"},      32'(wr_en),      32'(e_wr_en));
    check({ctx, ".done"},       32'(done),       32'(e_done));
    check({ctx, ".busy"},       32'(busy),       32'(m_active));
    check({ctx, ".data_ready"}, 32'(data_ready), 32'(m_active));
    check({ctx, ".sel"},        32'(sel),        32'(e_sel));
    check({ctx, ".wr_addr"},    32'(wr_addr),    32'(e_addr));
    check({ctx, ".wr_data"},    32'(wr_data),    32'(e_data));
  endtask

  // One clock: drive at the falling edge, model the rising edge, sample at the next falling edge.
  task automatic step(input string ctx, input bit s, input bit c, input bit v, input logic [DW-1:0] d);
    int ram;
    start = s; clear = c; data_valid = v; data_in = d;
    if (c) begin
      m_active = 0; m_k = 0; e_wr_en = 0; e_done = 0; e_sel = 4'hF;
    end else if (m_active && v) begin
      ram     = m_k / W;
      e_sel   = 4'((ram % NP) + 4 * (ram / NP));
      e_addr  = m_k % W;
      e_data  = int'(d);
      e_wr_en = 1;
      e_done  = (m_k == N - 1);
      m_k++;
      if (m_k == N) begin
        m_active = 0; m_k = 0;
      end
    end else begin
      e_wr_en = 0; e_done = 0;
      if (!m_active) begin
        e_sel = 4'hF;
        if (s) m_active = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (done) done_count++;
    check_outputs(ctx);
  endtask

  task automatic run_full(input string ctx);
    step(ctx, 1, 0, 1, 8'd0);
    for (int i = 0; i < N; i++) step(ctx, 0, 0, 1, DW'(i));
  endtask

  initial begin
    reset = 1'b0; start = 0; clear = 0; data_valid = 0; data_in = '0;
    done_count = 0;
    model_reset();
    @(negedge clk);
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    // idle: valid without start is never accepted
    for (int i = 0; i < 3; i++) step("idle", 0, 0, 1, 8'hAA);

    // full sequence with data 0..31
    done_count = 0;
    run_full("full");
    for (int i = 0; i < 2; i++) step("full_tail", 0, 0, 1, 8'h55);
    check("full.done_count", 32'(done_count), 32'd1);

    // backpressure: valid pattern 1,0,0,...
    done_count = 0;
    step("bp", 1, 0, 0, 8'd0);
    for (int i = 0; i < 200 && m_active; i++) step("bp", 0, 0, (i % 3) == 0, DW'(m_k));
    check("bp.finished", 32'(m_active), 32'd0);
    check("bp.done_count", 32'(done_count), 32'd1);

    // start pulsed at transfer 10 is ignored
    done_count = 0;
    step("sbusy", 1, 0, 1, 8'd0);
    for (int i = 0; i < N; i++) step("sbusy", i == 10, 0, 1, DW'(i));
    check("sbusy.done_count", 32'(done_count), 32'd1);
    step("sbusy_tail", 0, 0, 0, 8'd0);

    // clear coincident with transfer 20, then restart
    done_count = 0;
    step("clr", 1, 0, 1, 8'd0);
    for (int i = 0; i <= 20; i++) step("clr", 0, i == 20, 1, DW'(i));
    for (int i = 0; i < 3; i++) step("clr_idle", 0, 0, 1, 8'hEE);
    check("clr.done_count", 32'(done_count), 32'd0);
    run_full("clr_restart");
    step("clr_tail", 0, 0, 0, 8'd0);

    // back-to-back: start issued in the done cycle
    done_count = 0;
    run_full("b2b_a");
    check("b2b.done_seen", 32'(done), 32'd1);
    step("b2b_start", 1, 0, 1, 8'd0);
    check("b2b.ready_after_start", 32'(data_ready), 32'd1);
    for (int i = 0; i < N; i++) step("b2b_b", 0, 0, 1, DW'(i));
    step("b2b_tail", 0, 0, 0, 8'd0);
    check("b2b.done_count", 32'(done_count), 32'd2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step("rand", ($urandom % 8) == 0, ($urandom % 60) == 0, ($urandom % 2) == 0, DW'($urandom));
    end

    // asynchronous reset mid-sequence with valid held
    step("rst", 1, 0, 1, 8'd0);
    for (int i = 0; i < 7; i++) step("rst", 0, 0, 1, DW'(i + 100));
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_async");
    @(negedge clk);
    check_outputs("rst_held");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step("rst_after", 0, 0, 1, 8'h77);
    run_full("rst_restart");
    step("rst_tail", 0, 0, 0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
